// File: rtl/lu_defs.sv
// Shared opcode definitions for the bitwise logic unit and later ALU work.
package lu_defs;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'b000;
  localparam logic [OP_W-1:0] OP_NAND = 3'b001;
  localparam logic [OP_W-1:0] OP_OR   = 3'b010;
  localparam logic [OP_W-1:0] OP_NOR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
  localparam logic [OP_W-1:0] OP_XNOR = 3'b101;
  localparam logic [OP_W-1:0] OP_NOTA = 3'b110;
  localparam logic [OP_W-1:0] OP_PASS = 3'b111;

endpackage

// File: rtl/lu_bitwise.sv
// Purely combinational eight-way bitwise operation select.
module lu_bitwise
  import lu_defs::*;
#(
  parameter int WIDTH = 8
) (
  output logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op
);

  always_comb begin
    y = a;
    case (op)
      OP_AND:  y = a & b;
      OP_NAND: y = ~(a & b);
      OP_OR:   y = a | b;
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NOTA: y = ~a;
      OP_PASS: y = a;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with accumulator feedback, valid/ready output
// stage and a saturating count of accepted transactions.
module logic_unit_pipe
  import lu_defs::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  input  logic             use_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ones,
  output logic [CNT_W-1:0] op_count
);

  logic             out_valid_reg;
  logic [WIDTH-1:0] result_reg;
  logic             zero_reg;
  logic             ones_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [CNT_W-1:0] count_reg;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] y_next;
  logic             accept;

  assign b_eff    = use_acc ? acc_reg : b;
  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  lu_bitwise #(.WIDTH(WIDTH)) u_bitwise (
    .y  (y_next),
    .a  (a),
    .b  (b_eff),
    .op (op)
  );

  // Every data register loads only on accept, so idle-cycle inputs never reach state.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      zero_reg      <= 1'b1;
      ones_reg      <= 1'b0;
      acc_reg       <= '0;
      count_reg     <= '0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      result_reg    <= y_next;
      zero_reg      <= (y_next == '0);
      ones_reg      <= (y_next == '1);
      acc_reg       <= y_next;
      if (count_reg != '1) begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign zero      = zero_reg;
  assign ones      = ones_reg;
  assign op_count  = count_reg;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe (WIDTH=8, CNT_W=4): vector table plus
// hand-written backpressure, saturation and mid-stream reset sequences.
module tb_logic_unit_pipe;
  import lu_defs::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [OP_W-1:0]  op;
  logic             use_acc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             ones;
  logic [CNT_W-1:0] op_count;

  int tests;
  int fails;

  logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .use_acc   (use_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .ones      (ones),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             use_acc;
    logic [WIDTH-1:0] exp_result;
    logic             exp_zero;
    logic             exp_ones;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end else begin
      $display("[TB] ok   %s: 0x%0h", name, actual);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;

    vecs[0]  = '{OP_AND,  8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 1'b0};
    vecs[1]  = '{OP_NAND, 8'hF0, 8'h3C, 1'b0, 8'hCF, 1'b0, 1'b0};
    vecs[2]  = '{OP_OR,   8'hF0, 8'h3C, 1'b0, 8'hFC, 1'b0, 1'b0};
    vecs[3]  = '{OP_NOR,  8'hF0, 8'h3C, 1'b0, 8'h03, 1'b0, 1'b0};
    vecs[4]  = '{OP_XOR,  8'hF0, 8'h3C, 1'b0, 8'hCC, 1'b0, 1'b0};
    vecs[5]  = '{OP_XNOR, 8'hF0, 8'h3C, 1'b0, 8'h33, 1'b0, 1'b0};
    vecs[6]  = '{OP_NOTA, 8'hF0, 8'h3C, 1'b0, 8'h0F, 1'b0, 1'b0};
    vecs[7]  = '{OP_PASS, 8'hF0, 8'h3C, 1'b0, 8'hF0, 1'b0, 1'b0};
    vecs[8]  = '{OP_NOR,  8'h00, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1};
    vecs[9]  = '{OP_AND,  8'h0F, 8'hF0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{OP_PASS, 8'h5A, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b0};
    vecs[11] = '{OP_XOR,  8'hFF, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[12] = '{OP_XOR,  8'hFF, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    op        = OP_AND;
    use_acc   = 1'b0;

    tick();
    tick();
    reset = 1'b0;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result",    32'(result),    32'h00);
    check("reset zero",      32'(zero),      32'd1);
    check("reset ones",      32'(ones),      32'd0);
    check("reset op_count",  32'(op_count),  32'd0);
    check("reset in_ready",  32'(in_ready),  32'd1);

    // Back-to-back vectors: each result appears one cycle after its accept.
    out_ready = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      in_valid = 1'b1;
      op       = vecs[i].op;
      a        = vecs[i].a;
      b        = vecs[i].b;
      use_acc  = vecs[i].use_acc;
      tick();
      check($sformatf("vec%0d result", i),    32'(result),    32'(vecs[i].exp_result));
      check($sformatf("vec%0d zero", i),      32'(zero),      32'(vecs[i].exp_zero));
      check($sformatf("vec%0d ones", i),      32'(ones),      32'(vecs[i].exp_ones));
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d op_count", i),  32'(op_count),  32'(i + 1));
    end

    // Backpressure: result 0x5A pending, new transaction held for 3 cycles.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op        = OP_PASS;
    a         = 8'h11;
    use_acc   = 1'b0;
    #1;
    check("stall in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d result", i),    32'(result),    32'h5A);
      check($sformatf("stall%0d op_count", i),  32'(op_count),  32'd13);
      check($sformatf("stall%0d in_ready", i),  32'(in_ready),  32'd0);
      check($sformatf("stall%0d out_valid", i), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("release in_ready", 32'(in_ready), 32'd1);
    tick();
    check("release result",   32'(result),   32'h11);
    check("release op_count", 32'(op_count), 32'd14);

    in_valid = 1'b0;
    a        = 8'hEE;
    tick();
    check("drain out_valid", 32'(out_valid), 32'd0);
    check("drain result",    32'(result),    32'h11);
    check("drain op_count",  32'(op_count),  32'd14);

    // Saturation: 20 accepts starting from 14 must stop at 15.
    in_valid = 1'b1;
    op       = OP_PASS;
    for (int i = 0; i < 20; i++) begin
      a = 8'(i);
      tick();
      check($sformatf("sat%0d op_count", i), 32'(op_count), (14 + i + 1 > 15) ? 32'd15 : 32'(14 + i + 1));
      check($sformatf("sat%0d result", i),   32'(result),   32'(i));
    end

    // Reset while a result is pending and a new transaction is presented.
    reset = 1'b1;
    a     = 8'hAB;
    tick();
    reset = 1'b0;
    check("rst_mid out_valid", 32'(out_valid), 32'd0);
    check("rst_mid op_count",  32'(op_count),  32'd0);
    check("rst_mid result",    32'(result),    32'h00);
    check("rst_mid in_ready",  32'(in_ready),  32'd1);

    op      = OP_AND;
    use_acc = 1'b1;
    a       = 8'hFF;
    b       = 8'hFF;
    tick();
    check("acc_cleared result",   32'(result),   32'h00);
    check("acc_cleared zero",     32'(zero),     32'd1);
    check("acc_cleared op_count", 32'(op_count), 32'd1);
    in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the 1-bit AND/NAND/OR/NOR logic unit with cascaded 2:1 muxes.
- Performs one of eight bitwise operations on two WIDTH-bit operands, selected by a 3-bit opcode.
- Operand B can optionally be taken from an internal accumulator holding the last result.
- Results leave through a valid/ready output register with backpressure. It sits between a stimulus/control source and any downstream consumer in the lab datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- CNT_W, 8, width of the saturating operation counter (>=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands/opcode valid.
- in_ready  output  1  block can accept a transaction this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B (ignored when use_acc=1).
- op  input  3  opcode.
- use_acc  input  1  1: operand B := accumulator.
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  consumer accepts result this cycle.
- result  output  WIDTH  registered result.
- zero  output  1  registered: result == 0.
- ones  output  1  registered: result == all ones.
- op_count  output  CNT_W  number of accepted transactions, saturating.

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high, sampled on the rising edge and dominant over all other inputs.
- Reset values: out_valid=0, result=0, zero=1, ones=0, accumulator=0, op_count=0. in_ready=1 from the first cycle after reset.
- Opcodes:
  - 000 AND, 001 NAND, 010 OR, 011 NOR, 100 XOR, 101 XNOR.
  - 110 NOT A (B ignored), 111 PASS A.
  - All operations are bitwise across WIDTH. No carries, no width growth.
- Operand B source: B_eff = use_acc ? acc : b.
- Flow control:
  - in_ready = !out_valid || out_ready (combinational, no dependency on in_valid).
  - Accept = in_valid && in_ready.
- On accept:
  - result, zero and ones load f(op, a, B_eff) at the next edge.
  - out_valid <= 1.
  - acc <= the same new result.
  - op_count increments by 1, saturating at 2^CNT_W-1 (holds there, no wrap).
- Latency: exactly 1 cycle from accept to out_valid=1.
- Throughput: 1 transaction/cycle while out_ready=1.
- Drain: out_valid && out_ready && !accept -> out_valid <= 0. result, zero, ones and acc hold their values.
- Stall: out_valid && !out_ready -> in_ready=0. result, zero, ones, acc and op_count hold. in_valid may stay high without effect.
- Simultaneous drain and accept: out_valid stays 1 and the new result replaces the old one in the same edge.
- in_valid=0: no state change except the drain above.
- Reset mid-operation: any pending result is discarded. out_valid=0 on the next cycle and acc returns to 0. A transaction presented in the reset cycle is not accepted and op_count is not incremented.
- No X propagation: with in_valid=0, unknown a, b or op must not reach any register.

Decomposition:
- Shared package / include file `lu_defs`:
  - opcode localparams OP_AND .. OP_PASS.
  - opcode width constant (3).
- Sub-module `lu_bitwise`: purely combinational, parametrised by WIDTH, ports (y, a, b, op).
  - Implements the eight-way operation select.
  - Reusable by later ALU work.
- Top level holds handshake, result/flag registers, accumulator and counter.

Test Plan (WIDTH=8, CNT_W=4):
- Reset held 2 cycles, then released -> out_valid=0, result=0x00, zero=1, ones=0, op_count=0, in_ready=1.
- Operation sweep: a=0xF0, b=0x3C, out_ready=1, one op per cycle 000..111 -> results on consecutive cycles, one cycle after each accept: 0x30, 0xCF, 0xFC, 0x03, 0xCC, 0x33, 0x0F, 0xF0. Also NOR 0x00/0x00 -> 0xFF with ones=1; AND 0x0F/0xF0 -> 0x00 with zero=1.
- Accumulate chain: PASS a=0x5A, then XOR use_acc=1 with a=0xFF, then XOR use_acc=1 with a=0xFF -> 0x5A, 0xA5, 0x5A. The b port is driven 0x00 throughout and must have no effect.
- Backpressure: out_ready=0 with a result pending, in_valid=1 for 3 cycles -> in_ready=0, result and op_count frozen. Then out_ready=1 -> in_ready=1 in the same cycle, the held transaction is accepted and the new result appears the next cycle.
- Saturation: 20 back-to-back accepts -> op_count reaches 15 and stays 15.
- Reset mid-stream: assert reset while out_valid=1 and in_valid=1 -> next cycle out_valid=0, acc=0 (a following use_acc AND with a=0xFF gives 0x00), op_count=0.
